// File: rtl/ysyx_24070014_lsu_pkg.sv
// Shared encodings for the ysyx_24070014 load/store unit: access sizes,
// FSM states and the size-to-byte-count helper.
package ysyx_24070014_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_24070014_lsu_align.sv
// Combinational lane steering: store data/mask placement onto the bus lane,
// and load lane extraction with sign/zero extension.
module ysyx_24070014_lsu_align
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]                    size,
  input  logic                          uns,
  input  logic [$clog2(DATA_LEN/8)-1:0] off,
  input  logic [DATA_LEN-1:0]           wdata_in,
  output logic [DATA_LEN-1:0]           wdata_out,
  output logic [DATA_LEN/8-1:0]         wmask,
  input  logic [DATA_LEN-1:0]           rdata_in,
  output logic [DATA_LEN-1:0]           rdata_out
);
  localparam int NB = DATA_LEN / 8;

  logic [3:0]          nb;
  logic [6:0]          nbits;
  logic [DATA_LEN-1:0] sh, keep, top;
  logic                sgn;

  always_comb begin
    nb        = bytes_of(size);
    nbits     = {nb, 3'b000};
    wmask     = ~({NB{1'b1}} << nb) << off;
    wdata_out = wdata_in << {off, 3'b000};
    sh        = rdata_in >> {off, 3'b000};
    // keep covers the access width; its top bit is the sign position
    keep      = ~({DATA_LEN{1'b1}} << nbits);
    top       = keep ^ (keep >> 1);
    sgn       = ~uns & (|(sh & top));
    rdata_out = (sh & keep) | (sgn ? ~keep : '0);
  end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// Multi-cycle load/store unit bridging core requests to a valid/ready bus.
// Optional bus watchdog enabled by YSYX_24070014_LSU_TIMEOUT_EN.
module ysyx_24070014_lsu
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic [DATA_LEN/8-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_err,
  input  logic [DATA_LEN-1:0]   mem_rdata
);
  localparam int NB = DATA_LEN / 8;
  localparam int OW = $clog2(NB);

  typedef struct packed {
    logic                wen;
    logic [1:0]          size;
    logic                uns;
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata;
  } lsu_req_t;

  lsu_state_e          state;
  lsu_req_t            r;
  logic [DATA_LEN-1:0] rdata_q, wdata_al, rdata_ext;
  logic [NB-1:0]       wmask_al;
  logic                err_q;
  logic [3:0]          in_bytes;
  logic                bad, tmo;

  assign in_bytes = bytes_of(req_size);
  assign bad = (|({1'b0, req_addr[2:0]} & (in_bytes - 4'd1))) ||
               ((req_size == SIZE_D) && (DATA_LEN == 32));

`ifdef YSYX_24070014_LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  // fires on the last permitted cycle so RESP lands TIMEOUT cycles after REQ entry
  assign tmo = (cnt == CW'(TIMEOUT - 1));
`else
  // no watchdog: never times out (expression only keeps TIMEOUT referenced)
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      r       <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
      if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
`endif
      case (state)
        IDLE: if (req_valid) begin
          r.wen   <= req_wen;
          r.size  <= req_size;
          r.uns   <= req_unsigned;
          r.addr  <= req_addr;
          r.wdata <= req_wdata;
          rdata_q <= '0;
          err_q   <= bad;
          state   <= bad ? RESP : REQ;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        REQ: begin
          if (mem_ready && mem_resp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= mem_resp_err;
            state   <= RESP;
          end else if (tmo) begin
            err_q <= 1'b1;
            state <= RESP;
          end else if (mem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= mem_rdata;
            err_q   <= mem_resp_err;
            state   <= RESP;
          end else if (tmo) begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ysyx_24070014_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
    .size      (r.size),
    .uns       (r.uns),
    .off       (r.addr[OW-1:0]),
    .wdata_in  (r.wdata),
    .wdata_out (wdata_al),
    .wmask     (wmask_al),
    .rdata_in  (rdata_q),
    .rdata_out (rdata_ext)
  );

  // all outputs are forced low while reset is asserted
  assign req_ready  = reset && (state == IDLE);
  assign mem_valid  = reset && (state == REQ);
  assign mem_wen    = mem_valid && r.wen;
  assign mem_addr   = mem_valid ? {r.addr[ADDR_LEN-1:OW], {OW{1'b0}}} : '0;
  assign mem_wdata  = mem_wen ? wdata_al : '0;
  assign mem_wmask  = mem_wen ? wmask_al : '0;
  assign resp_valid = reset && (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !r.wen) ? rdata_ext : '0;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Directed, table-driven bench for ysyx_24070014_lsu plus multi-cycle sequences.
module tb_ysyx_24070014_lsu;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 0, req_ready, req_wen = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready = 0, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 0, mem_resp_err = 0;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  ysyx_24070014_lsu #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        merr;
    logic        bus, err;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic wen, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              logic merr, logic bus, logic err, logic [31:0] e_addr,
                              logic [31:0] e_wdata, logic [3:0] e_wmask, logic [31:0] e_rdata);
    vec_t v;
    v.name = n; v.wen = wen; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.merr = merr; v.bus = bus; v.err = err;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wmask = e_wmask; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " req_ready"}, req_ready, 1);
    issue(v.wen, v.size, v.uns, v.addr, v.wdata);
    if (!v.bus) begin
      chk({v.name, " no mem_valid"}, mem_valid, 0);
      chk({v.name, " resp 1cyc"}, resp_valid, 1);
    end else begin
      chk({v.name, " mem_valid"}, mem_valid, 1);
      chk({v.name, " mem_addr"}, mem_addr, v.e_addr);
      chk({v.name, " mem_wen"}, mem_wen, v.wen);
      if (v.wen) begin
        chk({v.name, " mem_wdata"}, mem_wdata, v.e_wdata);
        chk({v.name, " mem_wmask"}, mem_wmask, v.e_wmask);
      end
      chk({v.name, " resp early"}, resp_valid, 0);
      mem_ready = 1; mem_resp_valid = 1; mem_rdata = v.rdata; mem_resp_err = v.merr;
      @(negedge clk);
      mem_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
      chk({v.name, " resp_valid"}, resp_valid, 1);
    end
    chk({v.name, " resp_err"}, resp_err, v.err);
    chk({v.name, " resp_rdata"}, resp_rdata, v.e_rdata);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk({v.name, " resp drop"}, resp_valid, 0);
  endtask

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0]  = mk("lb",   0, 2'b00, 0, 32'h80000003, 0, 32'h80FF0000, 0, 1, 0, 32'h80000000, 0, 0, 32'hFFFFFF80);
    vecs[1]  = mk("lbu",  0, 2'b00, 1, 32'h80000003, 0, 32'h80FF0000, 0, 1, 0, 32'h80000000, 0, 0, 32'h00000080);
    vecs[2]  = mk("sh",   1, 2'b01, 0, 32'h80000002, 32'h0000BEEF, 0, 0, 1, 0, 32'h80000000, 32'hBEEF0000, 4'b1100, 0);
    vecs[3]  = mk("lw_mis", 0, 2'b10, 0, 32'h80000006, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[4]  = mk("lh",   0, 2'b01, 0, 32'h80000002, 0, 32'h80011234, 0, 1, 0, 32'h80000000, 0, 0, 32'hFFFF8001);
    vecs[5]  = mk("lhu",  0, 2'b01, 1, 32'h80000002, 0, 32'h80011234, 0, 1, 0, 32'h80000000, 0, 0, 32'h00008001);
    vecs[6]  = mk("lw",   0, 2'b10, 0, 32'h80000004, 0, 32'hDEADBEEF, 0, 1, 0, 32'h80000004, 0, 0, 32'hDEADBEEF);
    vecs[7]  = mk("sb",   1, 2'b00, 0, 32'h80000001, 32'h000000AB, 0, 0, 1, 0, 32'h80000000, 32'h0000AB00, 4'b0010, 0);
    vecs[8]  = mk("sw",   1, 2'b10, 0, 32'h80000008, 32'hCAFEF00D, 0, 0, 1, 0, 32'h80000008, 32'hCAFEF00D, 4'b1111, 0);
    vecs[9]  = mk("ld32", 0, 2'b11, 0, 32'h80000000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk("lb_pos", 0, 2'b00, 0, 32'h80000000, 0, 32'h1234567F, 0, 1, 0, 32'h80000000, 0, 0, 32'h0000007F);
    vecs[11] = mk("sh_mis", 1, 2'b01, 0, 32'h80000001, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk("sw_berr", 1, 2'b10, 0, 32'h8000000C, 32'h12345678, 0, 1, 1, 1, 32'h8000000C, 32'h12345678, 4'b1111, 0);
    vecs[13] = mk("lw_berr", 0, 2'b10, 0, 32'h80000010, 0, 32'hFFFFFFFF, 1, 1, 1, 32'h80000010, 0, 0, 0);

    // outputs held low during reset
    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst mem_valid", mem_valid, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst mem_addr", mem_addr, 0);
    reset = 1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // bus stall: 5 cycles of mem_ready low, stray mem_resp_valid ignored
    issue(0, 2'b01, 0, 32'h80000012, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall mem_valid", mem_valid, 1);
      chk("stall mem_addr", mem_addr, 32'h80000010);
      chk("stall mem_wen", mem_wen, 0);
      mem_resp_valid = (i == 2); mem_rdata = 32'h0BAD0BAD;
      @(negedge clk);
    end
    mem_ready = 1; mem_resp_valid = 1; mem_rdata = 32'hC3A50000;
    @(negedge clk);
    mem_ready = 0; mem_resp_valid = 0;
    chk("stall resp_valid", resp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold resp_valid", resp_valid, 1);
      chk("hold resp_rdata", resp_rdata, 32'hFFFFC3A5);
    end
    resp_ready = 1; @(negedge clk); resp_ready = 0;
    chk("hold done", resp_valid, 0);

    // split handshake through WAIT
    issue(0, 2'b00, 1, 32'h80000001, 0);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("wait mem_valid", mem_valid, 0);
    chk("wait resp_valid", resp_valid, 0);
    @(negedge clk);
    chk("wait still", resp_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h00009A00;
    @(negedge clk);
    mem_resp_valid = 0;
    chk("wait resp", resp_valid, 1);
    chk("wait rdata", resp_rdata, 32'h0000009A);
    resp_ready = 1; @(negedge clk); resp_ready = 0;

    // reset while in WAIT, then a late bus response
    issue(1, 2'b10, 0, 32'h80000020, 32'h55AA55AA);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    reset = 0;
    #1;
    chk("midrst req_ready", req_ready, 0);
    chk("midrst mem_valid", mem_valid, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    mem_resp_valid = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_resp_valid = 0;
    chk("late resp_valid", resp_valid, 0);
    chk("late req_ready", req_ready, 1);
    @(negedge clk);
    chk("late resp_valid2", resp_valid, 0);

`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    begin
      int k;
      issue(0, 2'b10, 0, 32'h80000030, 0);
      k = 0;
      while (!resp_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("tmo cycles", k, TMO);
      chk("tmo err", resp_err, 1);
      chk("tmo mem_valid", mem_valid, 0);
      resp_ready = 1; @(negedge clk); resp_ready = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_lsu.md
Name: ysyx_24070014_lsu

Overview:
Parametrised multi-cycle load/store unit that replaces the single-cycle, always-word, mask-less memory stage. It sits between the core's EX/WB control and a valid/ready memory bus, taking the place of direct paddr_read/paddr_write calls. It handles byte, half, word and (optionally) double accesses. It aligns write data and generates byte masks, and it sign- or zero-extends load data. Misaligned accesses are reported as an error response and never reach the bus.

Parameters:
ADDR_LEN, 32, address width
DATA_LEN, 32, bus/register data width; 32 or 64 only
TIMEOUT, 255, bus-wait cycle limit; used only when the watchdog macro is defined

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 double
req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
req_addr  in  ADDR_LEN  byte address
req_wdata  in  DATA_LEN  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  core accepts response
resp_rdata  out  DATA_LEN  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, unsupported size, bus error, or timeout
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_wen  out  1  bus write
mem_addr  out  ADDR_LEN  req_addr with low log2(DATA_LEN/8) bits cleared
mem_wdata  out  DATA_LEN  store data shifted to its byte lane
mem_wmask  out  DATA_LEN/8  byte enables
mem_resp_valid  in  1  bus completion, for reads and writes
mem_resp_err  in  1  bus error, qualified by mem_resp_valid
mem_rdata  in  DATA_LEN  full-width read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset value: state=IDLE. Every output is 0 while reset is low, and req_ready is also 0 during reset.
- After reset, req_ready = (state==IDLE). All other outputs are registered or decoded from registered state.
- IDLE:
  - On req_valid & req_ready, latch all req_* fields.
  - Misaligned request (addr mod bytes != 0), or size=11 with DATA_LEN=32: go to RESP with resp_err=1 and rdata=0. No bus traffic; resp_valid rises 1 cycle after accept.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1; mem_addr, mem_wen, mem_wdata, mem_wmask stay stable until mem_ready.
  - Write mask: wmask = ((1<<bytes)-1) << offset. Write data: wdata = req_wdata << (offset*8).
  - On mem_ready: if mem_resp_valid is high in the same cycle, go to RESP; otherwise go to WAIT.
  - mem_resp_valid without mem_ready is ignored.
- WAIT: mem_valid=0. On mem_resp_valid, capture mem_rdata and mem_resp_err, then go to RESP.
- RESP:
  - resp_valid=1 and held, with data stable, until resp_ready; then return to IDLE.
  - A new request is accepted no earlier than the cycle after the RESP handshake; there is no back-to-back overlap.
  - Loads: rdata = (mem_rdata >> offset*8), truncated to the access size, then sign- or zero-extended per the latched unsigned flag.
  - resp_err=1 forces rdata=0.
- Minimum latency from accept to resp_valid: 2 cycles for a bus access (mem_ready and mem_resp_valid in the same cycle), 1 cycle for a misaligned request.
- Reset mid-operation: next edge returns to IDLE and mem_valid drops. A late mem_resp_valid is ignored in IDLE.
- Stores never modify bytes outside wmask. A store response returns rdata=0.

Optional Feature:
YSYX_24070014_LSU_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to REQ and counts every cycle in REQ and WAIT.
  - When the count equals TIMEOUT, drop mem_valid and go to RESP with resp_err=1. Any later bus response is ignored.
- Undefined: no counter. The LSU waits indefinitely and TIMEOUT is unused.

Decomposition:
- Package ysyx_24070014_lsu_pkg holds:
  - size encodings (SIZE_B/H/W/D)
  - the FSM state enum
  - the function bytes_of(size)
- Sub-module ysyx_24070014_lsu_align is combinational:
  - store side: wdata shift and wmask generation
  - load side: lane extract and sign/zero extension
- The top module holds the FSM, request latch and watchdog.

Test Plan:
- lb addr 0x80000003, mem_rdata 0x80FF_0000 (byte 3 = 0x80): mem_addr 0x80000000, resp_rdata 0xFFFFFF80. Same access as lbu: resp_rdata 0x00000080.
- sh addr 0x80000002, wdata 0x0000BEEF: mem_wmask 4'b1100, mem_wdata 0xBEEF0000, resp_rdata 0, resp_err 0.
- lw addr 0x80000006: resp_valid 1 cycle after accept, resp_err 1, mem_valid never asserted.
- mem_ready held low 5 cycles: mem_* held stable throughout. Then mem_ready & mem_resp_valid in the same cycle: resp_valid the following cycle. resp_ready held low 3 cycles: resp_valid and resp_rdata hold.
- reset driven low while in WAIT, late mem_resp_valid pulse after release: LSU stays in IDLE and resp_valid stays 0.
- TIMEOUT_EN defined, TIMEOUT=10, mem_resp_valid never asserted: resp_err=1 exactly 10 cycles after entering REQ.
